// File: rtl/machine_trap_ctrl_if.sv
// Trap controller bundle: decode fields, exception/interrupt sources,
// and the PC/flush/CSR-strobe controls returned to the core.
interface machine_trap_ctrl_if #(
    parameter int NUM_PLAT_IRQ = 4,
    parameter int CAUSE_W      = 5
);
    logic                    illegal_instr_in;
    logic                    misaligned_instr_in;
    logic                    misaligned_load_in;
    logic                    misaligned_store_in;
    logic [4:0]              opcode_6_to_2_in;
    logic [2:0]              funct3_in;
    logic [6:0]              funct7_in;
    logic [4:0]              rs1_adder_in;
    logic [4:0]              rs2_adder_in;
    logic [4:0]              rd_adder_in;
    logic                    mie_in;
    logic                    meie_in;
    logic                    mtie_in;
    logic                    msie_in;
    logic                    meip_in;
    logic                    mtip_in;
    logic                    msip_in;
    logic                    eirq_in;
    logic                    tirq_in;
    logic                    sirq_in;
    logic [NUM_PLAT_IRQ-1:0] plat_irq_in;
    logic [NUM_PLAT_IRQ-1:0] plat_irq_en_in;
    logic [1:0]              pc_src_out;
    logic                    flush_out;
    logic                    trap_taken_out;
    logic                    instruct_inc_out;
    logic                    set_epc_out;
    logic                    set_cause_out;
    logic                    mie_clear_out;
    logic                    mie_set_out;
    logic                    i_or_e_out;
    logic [CAUSE_W-1:0]      cause_out;
    logic                    misaligned_exception_out;

    modport master (
        output illegal_instr_in, misaligned_instr_in,
        output misaligned_load_in, misaligned_store_in,
        output opcode_6_to_2_in, funct3_in, funct7_in,
        output rs1_adder_in, rs2_adder_in, rd_adder_in,
        output mie_in, meie_in, mtie_in, msie_in,
        output meip_in, mtip_in, msip_in,
        output eirq_in, tirq_in, sirq_in,
        output plat_irq_in, plat_irq_en_in,
        input  pc_src_out, flush_out, trap_taken_out,
        input  instruct_inc_out, set_epc_out, set_cause_out,
        input  mie_clear_out, mie_set_out, i_or_e_out,
        input  cause_out, misaligned_exception_out
    );

    modport slave (
        input  illegal_instr_in, misaligned_instr_in,
        input  misaligned_load_in, misaligned_store_in,
        input  opcode_6_to_2_in, funct3_in, funct7_in,
        input  rs1_adder_in, rs2_adder_in, rd_adder_in,
        input  mie_in, meie_in, mtie_in, msie_in,
        input  meip_in, mtip_in, msip_in,
        input  eirq_in, tirq_in, sirq_in,
        input  plat_irq_in, plat_irq_en_in,
        output pc_src_out, flush_out, trap_taken_out,
        output instruct_inc_out, set_epc_out, set_cause_out,
        output mie_clear_out, mie_set_out, i_or_e_out,
        output cause_out, misaligned_exception_out
    );
endinterface

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap controller: four-state trap FSM, interrupt/exception
// prioritisation and mcause generation for the RV32 core.
module machine_trap_ctrl #(
    parameter int NUM_PLAT_IRQ = 4,
    parameter int CAUSE_W      = 5,
    parameter int RESET_HOLD   = 2
) (
    input logic          clk_in,
    input logic          rst_in,
    machine_trap_ctrl_if.slave bus
);
    localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_OPERATING,
        ST_TRAP_TAKEN,
        ST_TRAP_RETURN
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               sys, ecall, ebreak, mret;
    logic               eip, sip, tip, ip, exc, trap_req;
    logic [NUM_PLAT_IRQ-1:0] pip;
    logic               ioe_q, ioe_nxt;
    logic [CAUSE_W-1:0] cause_q, cause_nxt, plat_code;
    logic               mis_q;
    logic [1:0]         pc_src;
    logic               flush, inc, tt, epc, setc, mclr, mset;

    assign sys = (bus.opcode_6_to_2_in == 5'b11100)
              && (bus.funct3_in == 3'd0)
              && (bus.rs1_adder_in == 5'd0)
              && (bus.rd_adder_in == 5'd0);
    assign ecall  = sys && (bus.rs2_adder_in == 5'd0)
                        && (bus.funct7_in == 7'd0);
    assign ebreak = sys && (bus.rs2_adder_in == 5'd1)
                        && (bus.funct7_in == 7'd0);
    assign mret   = sys && (bus.rs2_adder_in == 5'd2)
                        && (bus.funct7_in == 7'b0011000);

    assign eip = bus.meie_in & (bus.eirq_in | bus.meip_in);
    assign sip = bus.msie_in & (bus.sirq_in | bus.msip_in);
    assign tip = bus.mtie_in & (bus.tirq_in | bus.mtip_in);
    assign pip = bus.plat_irq_en_in & bus.plat_irq_in;
    assign ip  = eip | sip | tip | (|pip);
    assign exc = bus.illegal_instr_in | bus.misaligned_instr_in
               | bus.misaligned_load_in | bus.misaligned_store_in;
    assign trap_req = exc | (bus.mie_in & ip) | ecall | ebreak;

    // Descending scan so the lowest-index pending line wins
    always_comb begin
        plat_code = '0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            if (pip[i]) plat_code = CAUSE_W'(16 + i);
        end
    end

    always_comb begin
        ioe_nxt   = 1'b0;
        cause_nxt = '0;
        if (bus.mie_in && eip) begin
            ioe_nxt = 1'b1; cause_nxt = CAUSE_W'(11);
        end else if (bus.mie_in && sip) begin
            ioe_nxt = 1'b1; cause_nxt = CAUSE_W'(3);
        end else if (bus.mie_in && tip) begin
            ioe_nxt = 1'b1; cause_nxt = CAUSE_W'(7);
        end else if (bus.mie_in && (|pip)) begin
            ioe_nxt = 1'b1; cause_nxt = plat_code;
        end else if (bus.illegal_instr_in) begin
            cause_nxt = CAUSE_W'(2);
        end else if (bus.misaligned_instr_in) begin
            cause_nxt = CAUSE_W'(0);
        end else if (ecall) begin
            cause_nxt = CAUSE_W'(11);
        end else if (ebreak) begin
            cause_nxt = CAUSE_W'(3);
        end else if (bus.misaligned_store_in) begin
            cause_nxt = CAUSE_W'(6);
        end else if (bus.misaligned_load_in) begin
            cause_nxt = CAUSE_W'(4);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_src = 2'b00;
        flush  = 1'b0;
        inc    = 1'b0;
        tt     = 1'b0;
        epc    = 1'b0;
        setc   = 1'b0;
        mclr   = 1'b0;
        mset   = 1'b0;
        unique case (state)
            ST_RESET: begin
                flush = 1'b1;
                if (cnt == '0) state_nxt = ST_OPERATING;
            end
            ST_OPERATING: begin
                pc_src = 2'b01;
                inc    = ~trap_req;
                tt     = trap_req;
                if (trap_req)  state_nxt = ST_TRAP_TAKEN;
                else if (mret) state_nxt = ST_TRAP_RETURN;
            end
            ST_TRAP_TAKEN: begin
                pc_src = 2'b10;
                flush  = 1'b1;
                epc    = 1'b1;
                setc   = 1'b1;
                mclr   = 1'b1;
                state_nxt = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                pc_src = 2'b11;
                flush  = 1'b1;
                mset   = 1'b1;
                state_nxt = ST_OPERATING;
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_RESET;
            cnt     <= CNT_W'(RESET_HOLD - 1);
            ioe_q   <= 1'b0;
            cause_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RESET && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (state == ST_OPERATING && trap_req) begin
                ioe_q   <= ioe_nxt;
                cause_q <= cause_nxt;
            end
            mis_q <= bus.misaligned_instr_in | bus.misaligned_load_in
                   | bus.misaligned_store_in;
        end
    end

    assign bus.pc_src_out       = pc_src;
    assign bus.flush_out        = flush;
    assign bus.trap_taken_out   = tt;
    assign bus.instruct_inc_out = inc;
    assign bus.set_epc_out      = epc;
    assign bus.set_cause_out    = setc;
    assign bus.mie_clear_out    = mclr;
    assign bus.mie_set_out      = mset;
    assign bus.i_or_e_out       = ioe_q;
    assign bus.cause_out        = cause_q;
    assign bus.misaligned_exception_out = mis_q;
endmodule

// File: doc/machine_trap_ctrl.md
Name: machine_trap_ctrl

Overview:
Parametrised machine-mode trap controller for the single-issue RV32 core. It replaces the fixed reset/operating sequencer with a full four-state trap FSM. The block handles synchronous exceptions, ecall/ebreak/mret decode, and the standard external, software and timer interrupts. It also handles a configurable bank of platform interrupt lines. It drives PC-source select, pipeline flush and the CSR-file update strobes (mepc, mcause, mstatus.MIE).

Parameters:
NUM_PLAT_IRQ, 4, platform interrupt lines; legal 1..16; line i reports cause 16+i
CAUSE_W, 5, width of cause_out; must satisfy 2^CAUSE_W > 15+NUM_PLAT_IRQ
RESET_HOLD, 2, cycles spent in RESET after rst_in deasserts (legal >=1)

Ports:
clk_in  input  1  core clock
rst_in  input  1  reset: one clock; reset is synchronous and active-high
illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in  input  1 each  exception flags from decode/LSU
opcode_6_to_2_in  input  5  instr[6:2]
funct3_in  input  3  instr[14:12]
funct7_in  input  7  instr[31:25]
rs1_adder_in, rs2_adder_in, rd_adder_in  input  5 each  register fields
mie_in  input  1  mstatus.MIE
meie_in, mtie_in, msie_in  input  1 each  mie enables
meip_in, mtip_in, msip_in  input  1 each  mip pending bits
eirq_in, tirq_in, sirq_in  input  1 each  raw interrupt lines
plat_irq_in  input  NUM_PLAT_IRQ  platform interrupt lines, level-sensitive
plat_irq_en_in  input  NUM_PLAT_IRQ  per-line enable
pc_src_out  output  2  00 BOOT, 01 NEXT, 10 TRAP vector, 11 EPC
flush_out, trap_taken_out, instruct_inc_out  output  1 each
set_epc_out, set_cause_out, mie_clear_out, mie_set_out  output  1 each  CSR strobes
i_or_e_out  output  1  1 = interrupt, 0 = exception (mcause MSB)
cause_out  output  CAUSE_W  mcause code
misaligned_exception_out  output  1  registered misalignment pulse

Behaviour:
- Decode:
  - sys = opcode 11100, funct3 = 0, rs1 = 0, rd = 0.
  - ecall = sys & rs2 = 0 & funct7 = 0.
  - ebreak = sys & rs2 = 1 & funct7 = 0.
  - mret = sys & rs2 = 2 & funct7 = 0011000.
- Pending interrupts:
  - eip = meie&(eirq|meip); sip = msie&(sirq|msip); tip = mtie&(tirq|mtip).
  - pip[i] = plat_irq_en[i]&plat_irq[i].
  - ip = eip|sip|tip|(|pip).
- trap_req = exception flag | (mie_in & ip) | ecall | ebreak. Interrupts with mie_in = 0 never trap; exceptions always do.
- trap_taken_out = trap_req while in OPERATING; 0 in all other states (combinational).
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET: counter loads RESET_HOLD-1 on rst_in. Go to OPERATING when the counter reaches 0.
  - OPERATING: go to TRAP_TAKEN if trap_req. Otherwise go to TRAP_RETURN if mret. Otherwise stay.
  - TRAP_TAKEN and TRAP_RETURN: go to OPERATING after exactly one cycle. Inputs in these states are ignored because the instruction is being flushed.
- rst_in in any state: RESET on the next edge.
- Outputs per state, as pc_src / flush / instruct_inc / set_epc / set_cause / mie_clear / mie_set:
  - RESET: 00 / 1 / 0 / 0 / 0 / 0 / 0
  - OPERATING: 01 / 0 / !trap_req / 0 / 0 / 0 / 0
  - TRAP_TAKEN: 10 / 1 / 0 / 1 / 1 / 1 / 0
  - TRAP_RETURN: 11 / 1 / 0 / 0 / 0 / 0 / 1
- Cause register:
  - Loaded on the edge OPERATING->TRAP_TAKEN and held otherwise. Reset value: i_or_e 0, cause 0.
  - Priority, highest first:
    1. eip (1, 11)
    2. sip (1, 3)
    3. tip (1, 7)
    4. lowest-index pip[i] (1, 16+i)
    5. illegal (0, 2)
    6. misaligned_instr (0, 0)
    7. ecall (0, 11)
    8. ebreak (0, 3)
    9. misaligned_store (0, 6)
    10. misaligned_load (0, 4)
  - Interrupt rows apply only when mie_in = 1.
- Simultaneous trap_req and mret: the trap wins; mie_set is not pulsed.
- misaligned_exception_out is a register: next value = OR of the three misaligned flags. Reset 0. One-cycle latency.

Test Plan:
- rst_in high for 3 cycles then low, RESET_HOLD = 2 -> flush = 1 and pc_src = 00 for 2 cycles after release; then pc_src = 01, flush = 0, instruct_inc = 1.
- In OPERATING: mie = 1, meie = 1, eirq = 1, illegal = 1 in the same cycle -> trap_taken = 1 that cycle. Next cycle: pc_src = 10, set_epc = set_cause = mie_clear = 1, i_or_e = 1, cause = 11. Then back to OPERATING.
- plat_irq = 4'b0110, enables all 1, mie = 1, no other sources -> cause = 17, i_or_e = 1. With mie = 0 -> no trap, instruct_inc stays 1.
- mret encoding (opcode 11100, funct7 0011000, rs2 2, other fields 0) -> TRAP_RETURN for one cycle with pc_src = 11, flush = 1, mie_set = 1. Same with misaligned_load = 1 -> TRAP_TAKEN, cause = 4, mie_set stays 0.
- ecall then ebreak on consecutive traps -> cause 11 then 3, i_or_e 0. Input changes during TRAP_TAKEN leave cause unchanged.
- misaligned_store pulse 1 cycle -> misaligned_exception_out high exactly the following cycle. rst_in asserted while in TRAP_TAKEN -> RESET next edge, cause_out = 0, i_or_e_out = 0.
